// File: rtl/serv_csr_seq.sv
// serv_csr_seq: arbitrates CSR instructions, exceptions and the timer IRQ
// and sequences the bit-serial CSR block through each W-cycle pass.
module serv_csr_seq #(
  parameter int W     = 32,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_csr_req,
  input  logic [2:0]       i_csr_sel,
  input  logic [1:0]       i_csr_source,
  input  logic             i_trap_req,
  input  logic             i_mtip,
  input  logic             i_timer_irq_en,
  output logic             o_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic [2:0]       o_csr_sel,
  output logic [1:0]       o_csr_source,
  output logic             o_trap,
  output logic             o_pc_load,
  output logic             o_busy,
  output logic             o_csr_ack,
  output logic             o_trap_ack,
  output logic             o_irq_taken
);

  localparam logic [2:0] CSR_SEL_MTVEC  = 3'd1;
  localparam logic [2:0] CSR_SEL_MEPC   = 3'd2;
  localparam logic [1:0] CSR_SOURCE_CSR = 2'd0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CSR_RUN,
    TRAP_SAVE,
    TRAP_VEC,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       sel_q;
  logic [1:0]       src_q;
  logic             irq_flag;
  logic             trap_pass;
  logic             irq;
  logic             last;

  assign irq   = i_mtip & i_timer_irq_en;
  assign last  = (cnt == CNT_LAST);
  assign o_cnt = cnt;

  always_comb begin
    state_nxt    = state;
    o_en         = 1'b0;
    o_trap       = 1'b0;
    o_pc_load    = 1'b0;
    o_busy       = 1'b1;
    o_csr_ack    = 1'b0;
    o_trap_ack   = 1'b0;
    o_irq_taken  = 1'b0;
    o_csr_sel    = CSR_SEL_MEPC;
    o_csr_source = CSR_SOURCE_CSR;
    unique case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_trap_req | irq)
          state_nxt = TRAP_SAVE;
        else if (i_csr_req)
          state_nxt = CSR_RUN;
      end
      CSR_RUN: begin
        o_en         = 1'b1;
        o_csr_sel    = sel_q;
        o_csr_source = src_q;
        if (last)
          state_nxt = DONE;
      end
      TRAP_SAVE: begin
        o_en   = 1'b1;
        o_trap = 1'b1;
        if (last)
          state_nxt = TRAP_VEC;
      end
      TRAP_VEC: begin
        o_en      = 1'b1;
        o_pc_load = 1'b1;
        o_csr_sel = CSR_SEL_MTVEC;
        if (last)
          state_nxt = DONE;
      end
      DONE: begin
        o_csr_ack   = ~trap_pass;
        o_trap_ack  = trap_pass;
        o_irq_taken = trap_pass & irq_flag;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_q     <= CSR_SEL_MEPC;
      src_q     <= CSR_SOURCE_CSR;
      irq_flag  <= 1'b0;
      trap_pass <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        cnt <= '0;
        if (state_nxt != IDLE)
          trap_pass <= i_trap_req | irq;
        // an exception wins over a coincident IRQ, so no irq credit
        if (state_nxt != IDLE)
          irq_flag <= irq & ~i_trap_req;
        if (state_nxt == CSR_RUN) begin
          sel_q <= i_csr_sel;
          src_q <= i_csr_source;
        end
      end else if (o_en) begin
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (state == DONE)
        irq_flag <= 1'b0;
    end
  end

endmodule
